// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared constants for the I/D main-memory arbiter. This covers
//             the default widths, the FSM state encodings and the owner IDs.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  // Default widths: a 14-bit line address and a 64-bit line (four 16-bit words)
  localparam int ADDR_W_DEF = 14;
  localparam int LINE_W_DEF = 64;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Current owner of the memory port
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Line-transfer bus. The requester side uses the master modport
//             and the responder side uses the slave modport. The I port, the
//             D port and the main-memory port all share this shape.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
  parameter int LINE_W = mem_arb_pkg::LINE_W_DEF
);
  logic              re;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wr_data;
  logic              rdy;
  logic [LINE_W-1:0] rd_data;

  modport master (output re, we, lock, addr, wr_data, input rdy, rd_data);
  modport slave  (input re, we, lock, addr, wr_data, output rdy, rd_data);
endinterface
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pick
//  Purpose  : Combinational winner select for the memory arbiter.
//             MEM_ARB_RR_EN defined  : round-robin; rr_ptr=1 favours D.
//             MEM_ARB_RR_EN undefined: fixed D-over-I priority.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  wire logic       i_req,
  input  wire logic       d_req,
  input  wire logic       rr_ptr,
  output logic      [1:0] owner
);

`ifndef MEM_ARB_RR_EN
  // In the fixed-priority build the pointer does not affect the result
  logic w_unused_ptr;
  assign w_unused_ptr = rr_ptr;
`endif

  // Choose the owner from the active requests
  always_comb begin
    owner = OWN_NONE;
`ifdef MEM_ARB_RR_EN
    if (d_req && (!i_req || rr_ptr))
      owner = OWN_D;
    else if (i_req)
      owner = OWN_I;
`else
    if (d_req)
      owner = OWN_D;
    else if (i_req)
      owner = OWN_I;
`endif
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one main-memory port between the I-cache refill path
//             and the D-cache refill/write-back path. The owner's request is
//             latched at grant, and the module drives registered m_re/m_we/
//             m_addr/m_wr_data until m_rdy. It then pulses the owner's rdy
//             for one cycle and returns the line. With d_lock held, a D
//             write-back and the following refill stay atomic.
//  Config   : MEM_ARB_RR_EN selects round-robin arbitration in IDLE.
//             When it is undefined, D has fixed priority over I.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  mem_arbiter_if.slave  i_port,
  mem_arbiter_if.slave  d_port,
  mem_arbiter_if.master m_port
);

  logic [1:0]        r_state;
  logic [1:0]        r_owner;
  logic              r_lock;
  logic              r_m_re;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [LINE_W-1:0] r_m_wr_data;
  logic              r_i_rdy;
  logic              r_d_rdy;
  logic [LINE_W-1:0] r_i_rd_data;
  logic [LINE_W-1:0] r_d_rd_data;

  logic              w_d_req;
  logic              w_rr_ptr;
  logic [1:0]        w_pick;

  // The I side only reads, so its write, lock and data lines have no effect
  logic w_unused;
  assign w_unused = ^{i_port.we, i_port.lock, i_port.wr_data};

  assign w_d_req = d_port.re | d_port.we;

`ifdef MEM_ARB_RR_EN
  logic r_rr_ptr;

  // After each grant from IDLE, priority passes to the side that lost.
  // A locked D chain is granted once and therefore counts once.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_rr_ptr <= 1'b1;
    else if (r_state == ST_IDLE && w_pick != OWN_NONE)
      r_rr_ptr <= (w_pick == OWN_I);
  end

  assign w_rr_ptr = r_rr_ptr;
`else
  assign w_rr_ptr = 1'b1;
`endif

  mem_arb_pick u_pick (
    .i_req  (i_port.re),
    .d_req  (w_d_req),
    .rr_ptr (w_rr_ptr),
    .owner  (w_pick)
  );

  // Main FSM: grant in IDLE, hold the strobes in BUSY, pulse rdy in RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_NONE;
      r_lock      <= 1'b0;
      r_m_re      <= 1'b0;
      r_m_we      <= 1'b0;
      r_m_addr    <= '0;
      r_m_wr_data <= '0;
      r_i_rdy     <= 1'b0;
      r_d_rdy     <= 1'b0;
      r_i_rd_data <= '0;
      r_d_rd_data <= '0;
    end else begin
      r_i_rdy <= 1'b0;
      r_d_rdy <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_owner <= w_pick;
          if (w_pick == OWN_D) begin
            // A write takes precedence over a simultaneous read
            r_m_we      <= d_port.we;
            r_m_re      <= ~d_port.we;
            r_m_addr    <= d_port.addr;
            r_m_wr_data <= d_port.wr_data;
            r_state     <= ST_BUSY;
          end else if (w_pick == OWN_I) begin
            r_m_we      <= 1'b0;
            r_m_re      <= 1'b1;
            r_m_addr    <= i_port.addr;
            r_m_wr_data <= '0;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (m_port.rdy) begin
            if (r_m_re && r_owner == OWN_I)
              r_i_rd_data <= m_port.rd_data;
            if (r_m_re && r_owner == OWN_D)
              r_d_rd_data <= m_port.rd_data;
            r_i_rdy <= (r_owner == OWN_I);
            r_d_rdy <= (r_owner == OWN_D);
            r_lock  <= (r_owner == OWN_D) & d_port.lock;
            r_m_re  <= 1'b0;
            r_m_we  <= 1'b0;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          // No arbitration here. Only a locked D chain continues straight into BUSY.
          r_lock <= 1'b0;
          if (r_lock && w_d_req) begin
            r_m_we      <= d_port.we;
            r_m_re      <= ~d_port.we;
            r_m_addr    <= d_port.addr;
            r_m_wr_data <= d_port.wr_data;
            r_state     <= ST_BUSY;
          end else begin
            r_owner <= OWN_NONE;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_owner <= OWN_NONE;
          r_m_re  <= 1'b0;
          r_m_we  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_port.re      = r_m_re;
  assign m_port.we      = r_m_we;
  assign m_port.lock    = 1'b0;
  assign m_port.addr    = r_m_addr;
  assign m_port.wr_data = r_m_wr_data;

  assign i_port.rdy     = r_i_rdy;
  assign i_port.rd_data = r_i_rd_data;
  assign d_port.rdy     = r_d_rdy;
  assign d_port.rd_data = r_d_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter in the default
//             fixed-priority build. Inputs change on the falling edge, and
//             outputs are sampled on the falling edge as well.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  mem_arbiter_if #(.ADDR_W(14), .LINE_W(64)) i_if ();
  mem_arbiter_if #(.ADDR_W(14), .LINE_W(64)) d_if ();
  mem_arbiter_if #(.ADDR_W(14), .LINE_W(64)) m_if ();

  mem_arbiter #(.ADDR_W(14), .LINE_W(64)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_port (i_if),
    .d_port (d_if),
    .m_port (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    i_if.re = 0; i_if.we = 0; i_if.lock = 0; i_if.addr = '0; i_if.wr_data = '0;
    d_if.re = 0; d_if.we = 0; d_if.lock = 0; d_if.addr = '0; d_if.wr_data = '0;
    m_if.rdy = 0; m_if.rd_data = '0;
    tick(); tick();

    // Reset state
    check("rst_m_re",   64'(m_if.re),   64'd0);
    check("rst_m_we",   64'(m_if.we),   64'd0);
    check("rst_m_addr", 64'(m_if.addr), 64'd0);
    check("rst_i_rdy",  64'(i_if.rdy),  64'd0);
    check("rst_d_rdy",  64'(d_if.rdy),  64'd0);
    check("rst_i_data", i_if.rd_data,   64'd0);
    rst_n = 1'b1;
    tick();

    // 1: I read only, memory answers in the third BUSY cycle
    i_if.re = 1; i_if.addr = 14'h0010;
    tick();
    check("t1_m_re_c1",   64'(m_if.re),   64'd1);
    check("t1_m_we_c1",   64'(m_if.we),   64'd0);
    check("t1_m_addr_c1", 64'(m_if.addr), 64'h0010);
    tick();
    check("t1_m_re_c2",   64'(m_if.re),   64'd1);
    tick();
    check("t1_m_re_c3",   64'(m_if.re),   64'd1);
    check("t1_m_addr_c3", 64'(m_if.addr), 64'h0010);
    check("t1_i_rdy_c3",  64'(i_if.rdy),  64'd0);
    m_if.rdy = 1; m_if.rd_data = 64'h1111_2222_3333_4444;
    tick();
    m_if.rdy = 0;
    check("t1_i_rdy",   64'(i_if.rdy), 64'd1);
    check("t1_i_data",  i_if.rd_data,  64'h1111_2222_3333_4444);
    check("t1_m_re_rs", 64'(m_if.re),  64'd0);
    i_if.re = 0;
    tick();
    check("t1_i_rdy_off", 64'(i_if.rdy), 64'd0);
    check("t1_i_data_hold", i_if.rd_data, 64'h1111_2222_3333_4444);

    // 2: Simultaneous requests, D served first, then I
    i_if.re = 1; i_if.addr = 14'h0020;
    d_if.re = 1; d_if.addr = 14'h0030;
    tick();
    check("t2_d_addr", 64'(m_if.addr), 64'h0030);
    check("t2_d_re",   64'(m_if.re),   64'd1);
    m_if.rdy = 1; m_if.rd_data = 64'hAAAA_0000_0000_0001;
    tick();
    m_if.rdy = 0;
    check("t2_d_rdy",  64'(d_if.rdy), 64'd1);
    check("t2_i_rdy0", 64'(i_if.rdy), 64'd0);
    check("t2_d_data", d_if.rd_data,  64'hAAAA_0000_0000_0001);
    d_if.re = 0;
    tick();
    check("t2_idle_re", 64'(m_if.re), 64'd0);
    tick();
    check("t2_i_re",   64'(m_if.re),   64'd1);
    check("t2_i_addr", 64'(m_if.addr), 64'h0020);
    m_if.rdy = 1; m_if.rd_data = 64'hBBBB_0000_0000_0002;
    tick();
    m_if.rdy = 0;
    check("t2_i_rdy",       64'(i_if.rdy), 64'd1);
    check("t2_i_data",      i_if.rd_data,  64'hBBBB_0000_0000_0002);
    check("t2_d_data_hold", d_if.rd_data,  64'hAAAA_0000_0000_0001);
    i_if.re = 0;
    tick();

    // 3: Locked D write-back followed by a refill, with I pending throughout
    i_if.re = 1; i_if.addr = 14'h0040;
    d_if.we = 1; d_if.lock = 1; d_if.addr = 14'h3F01; d_if.wr_data = 64'hDEAD_BEEF_0000_0001;
    tick();
    check("t3_m_we",    64'(m_if.we),   64'd1);
    check("t3_m_re0",   64'(m_if.re),   64'd0);
    check("t3_w_addr",  64'(m_if.addr), 64'h3F01);
    check("t3_w_data",  m_if.wr_data,   64'hDEAD_BEEF_0000_0001);
    m_if.rdy = 1; m_if.rd_data = 64'h5555_5555_5555_5555;
    tick();
    m_if.rdy = 0;
    check("t3_wb_rdy",    64'(d_if.rdy), 64'd1);
    check("t3_wb_noload", d_if.rd_data,  64'hAAAA_0000_0000_0001);
    d_if.we = 0; d_if.re = 1; d_if.lock = 0; d_if.addr = 14'h0101;
    tick();
    check("t3_rf_re",   64'(m_if.re),   64'd1);
    check("t3_rf_we",   64'(m_if.we),   64'd0);
    check("t3_rf_addr", 64'(m_if.addr), 64'h0101);
    m_if.rdy = 1; m_if.rd_data = 64'hCCCC_0000_0000_0003;
    tick();
    m_if.rdy = 0;
    check("t3_rf_rdy",  64'(d_if.rdy), 64'd1);
    check("t3_rf_data", d_if.rd_data,  64'hCCCC_0000_0000_0003);
    check("t3_i_wait",  64'(i_if.rdy), 64'd0);
    d_if.re = 0;
    tick();
    check("t3_idle_re", 64'(m_if.re), 64'd0);
    tick();
    check("t3_i_re",   64'(m_if.re),   64'd1);
    check("t3_i_addr", 64'(m_if.addr), 64'h0040);
    m_if.rdy = 1; m_if.rd_data = 64'hDDDD_0000_0000_0004;
    tick();
    m_if.rdy = 0;
    check("t3_i_rdy",  64'(i_if.rdy), 64'd1);
    check("t3_i_data", i_if.rd_data,  64'hDDDD_0000_0000_0004);
    i_if.re = 0;
    tick();

    // 4: Request still high across RESP must not be granted again
    d_if.re = 1; d_if.addr = 14'h0111;
    tick();
    check("t4_m_re", 64'(m_if.re), 64'd1);
    m_if.rdy = 1; m_if.rd_data = 64'hEEEE_0000_0000_0005;
    tick();
    m_if.rdy = 0;
    check("t4_d_rdy", 64'(d_if.rdy), 64'd1);
    tick();
    check("t4_no_regrant", 64'(m_if.re),  64'd0);
    check("t4_rdy_once",   64'(d_if.rdy), 64'd0);
    d_if.re = 0;
    tick();
    check("t4_still_idle", 64'(m_if.re),  64'd0);
    check("t4_rdy_none",   64'(d_if.rdy), 64'd0);

    // 5: Reset mid-BUSY, then a late m_rdy
    i_if.re = 1; i_if.addr = 14'h0050;
    tick();
    check("t5_m_re", 64'(m_if.re), 64'd1);
    rst_n = 1'b0;
    tick();
    check("t5_rst_m_re",  64'(m_if.re),  64'd0);
    check("t5_rst_m_we",  64'(m_if.we),  64'd0);
    check("t5_rst_i_rdy", 64'(i_if.rdy), 64'd0);
    check("t5_rst_i_data", i_if.rd_data, 64'd0);
    rst_n = 1'b1; i_if.re = 0;
    m_if.rdy = 1; m_if.rd_data = 64'h7777_7777_7777_7777;
    tick();
    m_if.rdy = 0;
    check("t5_late_i_rdy", 64'(i_if.rdy), 64'd0);
    check("t5_late_m_re",  64'(m_if.re),  64'd0);
    tick();
    check("t5_late_i_rdy2", 64'(i_if.rdy), 64'd0);
    check("t5_late_d_rdy2", 64'(d_if.rdy), 64'd0);

    // 6: Stray m_rdy in IDLE, then d_re together with d_we
    m_if.rdy = 1; m_if.rd_data = 64'h8888_8888_8888_8888;
    tick();
    m_if.rdy = 0;
    check("t6_stray_d_rdy",  64'(d_if.rdy), 64'd0);
    check("t6_stray_i_rdy",  64'(i_if.rdy), 64'd0);
    check("t6_stray_d_data", d_if.rd_data,  64'd0);
    d_if.re = 1; d_if.we = 1; d_if.addr = 14'h0202; d_if.wr_data = 64'h0123_4567_89AB_CDEF;
    tick();
    check("t6_m_we",   64'(m_if.we),   64'd1);
    check("t6_m_re",   64'(m_if.re),   64'd0);
    check("t6_m_addr", 64'(m_if.addr), 64'h0202);
    m_if.rdy = 1; m_if.rd_data = 64'h9999_9999_9999_9999;
    tick();
    m_if.rdy = 0;
    check("t6_d_rdy",  64'(d_if.rdy), 64'd1);
    check("t6_d_data", d_if.rd_data,  64'd0);
    d_if.re = 0; d_if.we = 0;
    tick();
    check("t6_d_rdy_off", 64'(d_if.rdy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
